rob_commit: RTL and testbench

- In-order reorder buffer and commit stage of the out-of-order core.
- Receives renamed instructions from the rename stage: architectural destination, newly allocated physical tag, previous physical tag.
- Tracks execution completion and retires entries strictly in program order.
- Returns physical tags to the free-tag stack: the previous tag on normal commit, the new tag on exception squash. During squash it also drives rollback writes into the register allocation table.

---
 rtl/rob_commit_if.sv | 50 +++++
 rtl/rob_commit.sv | 164 ++++++++++++++++
 tb/tb_rob_commit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// rob_commit_if: handshake bundle between rename/execute and the ROB.
//   alloc_*    : rename presents areg, new ptag and previous ptag; ROB returns
//                alloc_ready and the tail index assigned (alloc_idx).
//   complete_* : execution reports completion (and exception) for a ROB index.
//   commit_*   : in-order retirement of the head entry.
//   free_*     : physical tag returned to the free-tag stack.
//   rb_*       : RAT rollback writes during a squash walk.
//   flush_done : one-cycle pulse at the end of a squash walk.
//   empty      : no valid entries.
// Modports: master = rename/execute side, slave = ROB.
interface rob_commit_if #(
  parameter int DEPTH  = 16,
  parameter int PTAG_W = 9,
  parameter int AREG_W = 5,
  parameter int IDX_W  = $clog2(DEPTH)
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [AREG_W-1:0] alloc_areg;
  logic [PTAG_W-1:0] alloc_ptag;
  logic [PTAG_W-1:0] alloc_old_ptag;
  logic [IDX_W-1:0]  alloc_idx;
  logic              complete_valid;
  logic [IDX_W-1:0]  complete_idx;
  logic              complete_exc;
  logic              commit_valid;
  logic [AREG_W-1:0] commit_areg;
  logic [PTAG_W-1:0] commit_ptag;
  logic              free_valid;
  logic [PTAG_W-1:0] free_ptag;
  logic              rb_valid;
  logic [AREG_W-1:0] rb_areg;
  logic [PTAG_W-1:0] rb_ptag;
  logic              flush_done;
  logic              empty;

  modport master (
    output alloc_valid, alloc_areg, alloc_ptag, alloc_old_ptag,
    output complete_valid, complete_idx, complete_exc,
    input  alloc_ready, alloc_idx, commit_valid, commit_areg, commit_ptag,
    input  free_valid, free_ptag, rb_valid, rb_areg, rb_ptag, flush_done, empty
  );

  modport slave (
    input  alloc_valid, alloc_areg, alloc_ptag, alloc_old_ptag,
    input  complete_valid, complete_idx, complete_exc,
    output alloc_ready, alloc_idx, commit_valid, commit_areg, commit_ptag,
    output free_valid, free_ptag, rb_valid, rb_areg, rb_ptag, flush_done, empty
  );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer and commit stage.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   rob   : rob_commit_if.slave (alloc, completion, commit, free, rollback)
// Entries retire in program order, one per cycle, returning old_ptag to the
// free stack. An excepting head entry starts a youngest-first squash walk that
// restores the RAT (rb_*) and frees each squashed entry's new ptag.
//
// state | meaning
// RUN   | allocate, complete and commit normally
// WALK  | squash from tail-1 down to head, one entry per cycle
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int PTAG_W = 9,
  parameter int AREG_W = 5,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  rob_commit_if.slave rob
);

  typedef enum logic {RUN, WALK} state_e;

  localparam logic [IDX_W:0]   PTR_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  state_e            state_q, state_d;
  logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
  logic [IDX_W-1:0]  walk_q, walk_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, exc_q, exc_d;
  logic [AREG_W-1:0] areg_q [DEPTH];
  logic [AREG_W-1:0] areg_d [DEPTH];
  logic [PTAG_W-1:0] ptag_q [DEPTH];
  logic [PTAG_W-1:0] ptag_d [DEPTH];
  logic [PTAG_W-1:0] old_q  [DEPTH];
  logic [PTAG_W-1:0] old_d  [DEPTH];

  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic              full, head_ok, alloc_ok;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign head_ok  = valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    walk_d  = walk_q;
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    areg_d  = areg_q;
    ptag_d  = ptag_q;
    old_d   = old_q;
    alloc_ok = 1'b0;

    rob.alloc_ready  = 1'b0;
    rob.alloc_idx    = tail_idx;
    rob.commit_valid = 1'b0;
    rob.commit_areg  = '0;
    rob.commit_ptag  = '0;
    rob.free_valid   = 1'b0;
    rob.free_ptag    = '0;
    rob.rb_valid     = 1'b0;
    rob.rb_areg      = '0;
    rob.rb_ptag      = '0;
    rob.flush_done   = 1'b0;
    rob.empty        = (head_q == tail_q);

    case (state_q)
      RUN: begin
        // Ready depends on registered state only; the exception-detect cycle
        // also blocks allocation so the walk starts from a stable tail.
        alloc_ok        = !full && !(head_ok && exc_q[head_idx]);
        rob.alloc_ready = alloc_ok;

        if (rob.complete_valid && valid_q[rob.complete_idx]) begin
          done_d[rob.complete_idx] = 1'b1;
          exc_d[rob.complete_idx]  = rob.complete_exc;
        end

        // Commit is evaluated after completion so a retiring head is cleared.
        if (head_ok) begin
          if (exc_q[head_idx]) begin
            state_d = WALK;
            walk_d  = tail_idx - IDX_ONE;
          end else begin
            rob.commit_valid  = 1'b1;
            rob.commit_areg   = areg_q[head_idx];
            rob.commit_ptag   = ptag_q[head_idx];
            rob.free_valid    = 1'b1;
            rob.free_ptag     = old_q[head_idx];
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            exc_d[head_idx]   = 1'b0;
            head_d            = head_q + PTR_ONE;
          end
        end

        if (rob.alloc_valid && alloc_ok) begin
          valid_d[tail_idx] = 1'b1;
          done_d[tail_idx]  = 1'b0;
          exc_d[tail_idx]   = 1'b0;
          areg_d[tail_idx]  = rob.alloc_areg;
          ptag_d[tail_idx]  = rob.alloc_ptag;
          old_d[tail_idx]   = rob.alloc_old_ptag;
          tail_d            = tail_q + PTR_ONE;
        end
      end

      WALK: begin
        rob.rb_valid    = 1'b1;
        rob.rb_areg     = areg_q[walk_q];
        rob.rb_ptag     = old_q[walk_q];
        rob.free_valid  = 1'b1;
        rob.free_ptag   = ptag_q[walk_q];
        valid_d[walk_q] = 1'b0;
        done_d[walk_q]  = 1'b0;
        exc_d[walk_q]   = 1'b0;
        if (walk_q == head_idx) begin
          rob.flush_done = 1'b1;
          tail_d         = head_q;
          state_d        = RUN;
        end else begin
          walk_d = walk_q - IDX_ONE;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      walk_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      walk_q  <= walk_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    areg_q <= areg_d;
    ptag_q <= ptag_d;
    old_q  <= old_d;
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed, table-driven bench for rob_commit.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, i.e. they reflect the state after the previous rising edge.
module tb_rob_commit;
  localparam int DEPTH = 16, PTAG_W = 9, AREG_W = 5, IDX_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if #(.DEPTH(DEPTH), .PTAG_W(PTAG_W), .AREG_W(AREG_W), .IDX_W(IDX_W)) bus ();

  rob_commit #(.DEPTH(DEPTH), .PTAG_W(PTAG_W), .AREG_W(AREG_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int rst;
    int av, areg, ptag, old;
    int cv, cidx, cexc;
    int e_rdy, e_idx;
    int e_cv, e_careg, e_cptag;
    int e_fv, e_fptag;
    int e_rv, e_rareg, e_rptag;
    int e_fd, e_emp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input int av, input int areg, input int ptag, input int old,
                       input int cv, input int cidx, input int cexc);
    bus.alloc_valid    = av[0];
    bus.alloc_areg     = AREG_W'(areg);
    bus.alloc_ptag     = PTAG_W'(ptag);
    bus.alloc_old_ptag = PTAG_W'(old);
    bus.complete_valid = cv[0];
    bus.complete_idx   = IDX_W'(cidx);
    bus.complete_exc   = cexc[0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d_ready", i),     int'(bus.alloc_ready),  v.e_rdy);
    chk($sformatf("v%0d_idx", i),       int'(bus.alloc_idx),    v.e_idx);
    chk($sformatf("v%0d_commit_v", i),  int'(bus.commit_valid), v.e_cv);
    chk($sformatf("v%0d_commit_ar", i), int'(bus.commit_areg),  v.e_careg);
    chk($sformatf("v%0d_commit_pt", i), int'(bus.commit_ptag),  v.e_cptag);
    chk($sformatf("v%0d_free_v", i),    int'(bus.free_valid),   v.e_fv);
    chk($sformatf("v%0d_free_pt", i),   int'(bus.free_ptag),    v.e_fptag);
    chk($sformatf("v%0d_rb_v", i),      int'(bus.rb_valid),     v.e_rv);
    chk($sformatf("v%0d_rb_ar", i),     int'(bus.rb_areg),      v.e_rareg);
    chk($sformatf("v%0d_rb_pt", i),     int'(bus.rb_ptag),      v.e_rptag);
    chk($sformatf("v%0d_flush", i),     int'(bus.flush_done),   v.e_fd);
    chk($sformatf("v%0d_empty", i),     int'(bus.empty),        v.e_emp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst | av areg ptag old | cv cidx cexc | rdy idx | cv careg cptag | fv fptag | rv rareg rptag | fd emp
    // In-order commit with out-of-order completion.
    vecs[0]  = '{1, 1,1,20,1, 0,0,0, 1,0, 0,0,0,  0,0, 0,0,0, 0,1};
    vecs[1]  = '{0, 1,2,21,2, 0,0,0, 1,1, 0,0,0,  0,0, 0,0,0, 0,0};
    vecs[2]  = '{0, 1,3,22,3, 0,0,0, 1,2, 0,0,0,  0,0, 0,0,0, 0,0};
    vecs[3]  = '{0, 0,0,0,0,  1,2,0, 1,3, 0,0,0,  0,0, 0,0,0, 0,0};
    vecs[4]  = '{0, 0,0,0,0,  1,0,0, 1,3, 0,0,0,  0,0, 0,0,0, 0,0};
    vecs[5]  = '{0, 0,0,0,0,  1,1,0, 1,3, 1,1,20, 1,1, 0,0,0, 0,0};
    vecs[6]  = '{0, 0,0,0,0,  0,0,0, 1,3, 1,2,21, 1,2, 0,0,0, 0,0};
    vecs[7]  = '{0, 0,0,0,0,  0,0,0, 1,3, 1,3,22, 1,3, 0,0,0, 0,0};
    vecs[8]  = '{0, 0,0,0,0,  0,0,0, 1,3, 0,0,0,  0,0, 0,0,0, 0,1};
    // Exception at head: transition cycle then 4-cycle youngest-first walk.
    vecs[9]  = '{1, 1,5,30,5, 0,0,0, 1,0, 0,0,0,  0,0,  0,0,0, 0,1};
    vecs[10] = '{0, 1,6,31,6, 0,0,0, 1,1, 0,0,0,  0,0,  0,0,0, 0,0};
    vecs[11] = '{0, 1,7,32,7, 0,0,0, 1,2, 0,0,0,  0,0,  0,0,0, 0,0};
    vecs[12] = '{0, 1,8,33,8, 0,0,0, 1,3, 0,0,0,  0,0,  0,0,0, 0,0};
    vecs[13] = '{0, 0,0,0,0,  1,0,1, 1,4, 0,0,0,  0,0,  0,0,0, 0,0};
    vecs[14] = '{0, 1,9,34,9, 0,0,0, 0,4, 0,0,0,  0,0,  0,0,0, 0,0};
    vecs[15] = '{0, 1,9,34,9, 0,0,0, 0,4, 0,0,0,  1,33, 1,8,8, 0,0};
    vecs[16] = '{0, 0,0,0,0,  1,1,0, 0,4, 0,0,0,  1,32, 1,7,7, 0,0};
    vecs[17] = '{0, 0,0,0,0,  0,0,0, 0,4, 0,0,0,  1,31, 1,6,6, 0,0};
    vecs[18] = '{0, 0,0,0,0,  0,0,0, 0,4, 0,0,0,  1,30, 1,5,5, 1,0};
    vecs[19] = '{0, 0,0,0,0,  0,0,0, 1,0, 0,0,0,  0,0,  0,0,0, 0,1};

    idle();
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst != 0) reset_dut();
      @(negedge clk);
      drive(vecs[i].av, vecs[i].areg, vecs[i].ptag, vecs[i].old,
            vecs[i].cv, vecs[i].cidx, vecs[i].cexc);
      #1;
      check_vec(i, vecs[i]);
    end

    // Fill to full, commit while alloc is held off, then wrap the tail.
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1, i, 100 + i, 200 + i, 0, 0, 0);
      #1;
      chk("fill_ready", int'(bus.alloc_ready), 1);
      chk("fill_idx", int'(bus.alloc_idx), i);
    end
    @(negedge clk);
    drive(1, 31, 150, 250, 1, 0, 0);
    #1;
    chk("full_ready", int'(bus.alloc_ready), 0);
    chk("full_empty", int'(bus.empty), 0);
    chk("full_no_commit", int'(bus.commit_valid), 0);
    @(negedge clk);
    drive(1, 31, 150, 250, 0, 0, 0);
    #1;
    chk("full_commit_ready", int'(bus.alloc_ready), 0);
    chk("full_commit_v", int'(bus.commit_valid), 1);
    chk("full_commit_pt", int'(bus.commit_ptag), 100);
    chk("full_free_pt", int'(bus.free_ptag), 200);
    @(negedge clk);
    drive(1, 31, 150, 250, 0, 0, 0);
    #1;
    chk("wrap_ready", int'(bus.alloc_ready), 1);
    chk("wrap_idx", int'(bus.alloc_idx), 0);
    chk("wrap_no_commit", int'(bus.commit_valid), 0);
    @(negedge clk);
    idle();
    #1;
    chk("refull_ready", int'(bus.alloc_ready), 0);
    chk("refull_idx", int'(bus.alloc_idx), 1);

    // Advance head to index 14, then squash 4 entries across index 0.
    reset_dut();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(1, i, i, i, (i > 0) ? 1 : 0, (i > 0) ? i - 1 : 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 13, 0);
    begin
      int k = 0;
      do begin
        @(negedge clk);
        idle();
        #1;
        k++;
      end while (!bus.empty && k < 40);
    end
    chk("sq_drained", int'(bus.empty), 1);
    chk("sq_head14", int'(bus.alloc_idx), 14);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 10 + k, 40 + k, 60 + k, 0, 0, 0);
      #1;
      chk("sq_alloc_idx", int'(bus.alloc_idx), (14 + k) % DEPTH);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 14, 1);
    #1;
    chk("sq_tail", int'(bus.alloc_idx), 2);
    @(negedge clk);
    idle();
    #1;
    chk("sq_trans_ready", int'(bus.alloc_ready), 0);
    chk("sq_trans_rb", int'(bus.rb_valid), 0);
    chk("sq_trans_commit", int'(bus.commit_valid), 0);
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      idle();
      #1;
      chk("sq_walk_rb_v", int'(bus.rb_valid), 1);
      chk("sq_walk_free_pt", int'(bus.free_ptag), 40 + k);
      chk("sq_walk_rb_pt", int'(bus.rb_ptag), 60 + k);
      chk("sq_walk_rb_ar", int'(bus.rb_areg), 10 + k);
      chk("sq_walk_commit", int'(bus.commit_valid), 0);
      chk("sq_walk_flush", int'(bus.flush_done), (k == 0) ? 1 : 0);
    end
    @(negedge clk);
    idle();
    #1;
    chk("sq_end_empty", int'(bus.empty), 1);
    chk("sq_end_ready", int'(bus.alloc_ready), 1);
    chk("sq_end_idx", int'(bus.alloc_idx), 14);

    // Reset asserted during the second walk cycle.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1 + k, 70 + k, 80 + k, 0, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    idle();
    #1;
    chk("rw_walk1_rb_v", int'(bus.rb_valid), 1);
    chk("rw_walk1_rb_pt", int'(bus.rb_ptag), 82);
    @(negedge clk);
    idle();
    #1;
    chk("rw_walk2_rb_v", int'(bus.rb_valid), 1);
    chk("rw_walk2_free_pt", int'(bus.free_ptag), 71);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rw_empty", int'(bus.empty), 1);
    chk("rw_ready", int'(bus.alloc_ready), 1);
    chk("rw_rb_v", int'(bus.rb_valid), 0);
    chk("rw_free_v", int'(bus.free_valid), 0);
    chk("rw_flush", int'(bus.flush_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
